// File: rtl/pixel_cmd_fifo.sv
// First-word-fall-through command FIFO between the slave arbiter and the processing master.
// Define PIXEL_CMD_FIFO_DROP_CNT_EN to count pushes dropped on overflow.
module pixel_cmd_fifo #(
  parameter int DW          = 32,
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       slvx_data_valid,
  input  logic [1:0]                 slvx_mode,
  input  logic [7:0]                 slvx_proc_val,
  input  logic [DW-1:0]              slvx_data,
  output logic                       fifo_full,
  input  logic                       mstr_rd_en,
  output logic                       mstr_valid,
  output logic [1:0]                 mstr_mode,
  output logic [7:0]                 mstr_proc_val,
  output logic [DW-1:0]              mstr_data,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH - FULL_MARGIN);

  typedef struct packed {
    logic [1:0]    mode;
    logic [7:0]    proc_val;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  entry_t          wr_entry;
  entry_t          head;
  logic            pop_ok;
  logic            push_ok;
  logic            drop;

  assign wr_entry = '{mode: slvx_mode, proc_val: slvx_proc_val, data: slvx_data};

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop_ok  = mstr_rd_en && (count != '0);
  assign push_ok = slvx_data_valid && ((count < COUNT_MAX) || pop_ok);
  assign drop    = slvx_data_valid && !push_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are live, and leaving it unreset lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= wr_entry;
  end

`ifdef PIXEL_CMD_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_cnt    = 16'h0000;
`endif

  // NOTE: head defaults to zero before any conditional assignment so the
  // combinational block cannot infer a latch.
  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

  assign fifo_full     = (count >= FULL_LEVEL);
  assign fifo_empty    = (count == '0);
  assign mstr_valid    = !fifo_empty;
  assign fifo_count    = count;
  assign mstr_mode     = head.mode;
  assign mstr_proc_val = head.proc_val;
  assign mstr_data     = head.data;

endmodule

// File: tb/tb_pixel_cmd_fifo.sv
// Directed self-checking bench for pixel_cmd_fifo (DW=32, DEPTH=16, FULL_MARGIN=2).
module tb_pixel_cmd_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

`ifdef PIXEL_CMD_FIFO_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd3;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          slvx_data_valid;
  logic [1:0]    slvx_mode;
  logic [7:0]    slvx_proc_val;
  logic [DW-1:0] slvx_data;
  logic          fifo_full;
  logic          mstr_rd_en;
  logic          mstr_valid;
  logic [1:0]    mstr_mode;
  logic [7:0]    mstr_proc_val;
  logic [DW-1:0] mstr_data;
  logic          fifo_empty;
  logic [4:0]    fifo_count;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_cmd_fifo #(.DW(DW), .DEPTH(DEPTH), .FULL_MARGIN(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .slvx_data_valid (slvx_data_valid),
    .slvx_mode       (slvx_mode),
    .slvx_proc_val   (slvx_proc_val),
    .slvx_data       (slvx_data),
    .fifo_full       (fifo_full),
    .mstr_rd_en      (mstr_rd_en),
    .mstr_valid      (mstr_valid),
    .mstr_mode       (mstr_mode),
    .mstr_proc_val   (mstr_proc_val),
    .mstr_data       (mstr_data),
    .fifo_empty      (fifo_empty),
    .fifo_count      (fifo_count),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1ns after the edge.
  task automatic cycle(input logic r, input logic push, input logic [1:0] mode,
                       input logic [7:0] pv, input logic [DW-1:0] data, input logic pop);
    rst             = r;
    slvx_data_valid = push;
    slvx_mode       = mode;
    slvx_proc_val   = pv;
    slvx_data       = data;
    mstr_rd_en      = pop;
    @(posedge clk);
    #1;
    rst             = 1'b0;
    slvx_data_valid = 1'b0;
    mstr_rd_en      = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [1:0] mode,
                            input logic [7:0] pv, input logic [DW-1:0] data);
    check({tag, ".valid"}, 64'(mstr_valid), 64'd1);
    check({tag, ".mode"},  64'(mstr_mode), 64'(mode));
    check({tag, ".pv"},    64'(mstr_proc_val), 64'(pv));
    check({tag, ".data"},  64'(mstr_data), 64'(data));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(mstr_valid), 64'd0);
    check({tag, ".empty"}, 64'(fifo_empty), 64'd1);
    check({tag, ".count"}, 64'(fifo_count), 64'd0);
    check({tag, ".full"},  64'(fifo_full), 64'd0);
    check({tag, ".mode"},  64'(mstr_mode), 64'd0);
    check({tag, ".pv"},    64'(mstr_proc_val), 64'd0);
    check({tag, ".data"},  64'(mstr_data), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    m;
    logic [7:0]    p;

    rst = 1'b1; slvx_data_valid = 1'b0; slvx_mode = '0; slvx_proc_val = '0;
    slvx_data = '0; mstr_rd_en = 1'b0;

    // Reset for two cycles
    cycle(1'b1, 1'b0, 2'd0, 8'd0, '0, 1'b0);
    cycle(1'b1, 1'b0, 2'd0, 8'd0, '0, 1'b0);
    check_idle("reset");
    check("reset.drop", 64'(drop_cnt), 64'd0);

    // Basic push then pop
    cycle(1'b0, 1'b1, 2'b01, 8'h3C, 32'hDEADBEEF, 1'b0);
    check_head("basic", 2'b01, 8'h3C, 32'hDEADBEEF);
    check("basic.count", 64'(fifo_count), 64'd1);
    cycle(1'b0, 1'b0, 2'd0, 8'd0, '0, 1'b1);
    check_idle("basic_pop");

    // Fill 16 entries; write pointer starts at 1 so the fill wraps
    for (int i = 0; i < 16; i++) begin
      d = DW'(i); m = 2'(i); p = 8'(i + 8'h40);
      cycle(1'b0, 1'b1, m, p, d, 1'b0);
      check($sformatf("fill%0d.full", i), 64'(fifo_full), 64'((i + 1) >= 14));
      check($sformatf("fill%0d.count", i), 64'(fifo_count), 64'(i + 1));
    end
    check_head("fill_head", 2'd0, 8'h40, 32'd0);

    // Overflow: three pushes of 99 while full
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd3, 8'hFF, 32'd99, 1'b0);
    check("ovf.count", 64'(fifo_count), 64'd16);
    check("ovf.drop",  64'(drop_cnt), 64'(EXP_DROP));
    check_head("ovf_head", 2'd0, 8'h40, 32'd0);

    // Push and pop together while full: entry 0 leaves, entry 100 joins the tail
    cycle(1'b0, 1'b1, 2'd2, 8'hA5, 32'd100, 1'b1);
    check("fullpp.count", 64'(fifo_count), 64'd16);
    check("fullpp.full",  64'(fifo_full), 64'd1);
    check("fullpp.drop",  64'(drop_cnt), 64'(EXP_DROP));

    // Drain: 1..15 in order, then 100
    for (int i = 1; i < 16; i++) begin
      d = DW'(i); m = 2'(i); p = 8'(i + 8'h40);
      check_head($sformatf("drain%0d", i), m, p, d);
      cycle(1'b0, 1'b0, 2'd0, 8'd0, '0, 1'b1);
      check($sformatf("drain%0d.count", i), 64'(fifo_count), 64'(16 - i));
    end
    check_head("drain_last", 2'd2, 8'hA5, 32'd100);
    cycle(1'b0, 1'b0, 2'd0, 8'd0, '0, 1'b1);
    check_idle("drained");

    // Push and pop together while empty: pop ignored, push stored
    cycle(1'b0, 1'b1, 2'd1, 8'h11, 32'd55, 1'b1);
    check("emptypp.count", 64'(fifo_count), 64'd1);
    check_head("emptypp", 2'd1, 8'h11, 32'd55);
    cycle(1'b0, 1'b0, 2'd0, 8'd0, '0, 1'b1);
    check_idle("emptypp_pop");

    // Pop while empty for five cycles
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 2'd0, 8'd0, '0, 1'b1);
      check($sformatf("epop%0d.count", i), 64'(fifo_count), 64'd0);
      check($sformatf("epop%0d.empty", i), 64'(fifo_empty), 64'd1);
    end
    cycle(1'b0, 1'b1, 2'd3, 8'h22, 32'h77, 1'b0);
    check_head("after_epop", 2'd3, 8'h22, 32'h77);
    check("after_epop.count", 64'(fifo_count), 64'd1);
    cycle(1'b0, 1'b0, 2'd0, 8'd0, '0, 1'b1);
    check_idle("after_epop_pop");

    // Reset mid-operation with a push in the reset cycle
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 2'd1, 8'h33, DW'(200 + i), 1'b0);
    check("pre_rst.count", 64'(fifo_count), 64'd7);
    cycle(1'b1, 1'b1, 2'd2, 8'h44, 32'd300, 1'b1);
    check_idle("mid_rst");
    check("mid_rst.drop", 64'(drop_cnt), 64'd0);
    cycle(1'b0, 1'b1, 2'd2, 8'h5A, 32'h1234, 1'b0);
    check_head("post_rst", 2'd2, 8'h5A, 32'h1234);
    check("post_rst.count", 64'(fifo_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_cmd_fifo.md
# pixel_cmd_fifo

Synchronous first-word-fall-through FIFO that sits directly downstream of the two-slave arbiter in the image-processing accelerator. Each cycle the arbiter presents a valid pixel command, the FIFO stores the mode, processing value and data word as one entry. It drives `fifo_full` back to the arbiter for flow control. The processing master drains entries with a pop strobe.

## Interface
- `DW`, 32, pixel data width.
- `DEPTH`, 16, number of entries; power of two, minimum 4.
- `FULL_MARGIN`, 2, free-slot headroom at which `fifo_full` asserts. It absorbs the arbiter's registered-output latency. Legal range 1..DEPTH-1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `slvx_data_valid`  in  1  push strobe from the arbiter.
- `slvx_mode`  in  2  command mode.
- `slvx_proc_val`  in  8  processing value.
- `slvx_data`  in  DW  pixel data.
- `fifo_full`  out  1  backpressure to the arbiter.
- `mstr_rd_en`  in  1  pop strobe from the processing master.
- `mstr_valid`  out  1  head entry present (not empty).
- `mstr_mode`  out  2  head entry mode.
- `mstr_proc_val`  out  8  head entry processing value.
- `mstr_data`  out  DW  head entry data.
- `fifo_empty`  out  1  count == 0.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `drop_cnt`  out  16  dropped pushes; see Configuration.

## Operation
- **Entry format:** `{mode[1:0], proc_val[7:0], data[DW-1:0]}`, stored in a register array of DEPTH entries.
- **Pointers:**
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide.
  - They wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked by a separate `count` register.
- **Push:**
  - Accepted when `slvx_data_valid`=1 and (`count` < DEPTH, or a pop is accepted in the same cycle).
  - The entry is written at `wr_ptr`, and `wr_ptr` increments.
  - Every cycle with `slvx_data_valid`=1 is a distinct push. The arbiter is responsible for deasserting valid.
- **Pop:**
  - Accepted when `mstr_rd_en`=1 and `count` > 0. `rd_ptr` increments.
  - A pop when empty is ignored: no pointer or count change.
- **Count update:**
  - Push only: +1.
  - Pop only: -1.
  - Both accepted: unchanged.
- **Simultaneous events:**
  - Push and pop while empty: the pop is ignored and the push is stored; count goes to 1.
  - Push and pop while full: both are accepted; count stays at DEPTH.
- **Overflow:** a push with `count`==DEPTH and no pop is dropped. Memory and pointers are unchanged.
- **Flags:**
  - `fifo_full` = (`count` >= DEPTH-FULL_MARGIN), combinational from the registered count.
  - `fifo_empty` = (`count`==0).
  - `mstr_valid` = !`fifo_empty`.
- **Head outputs:**
  - `mstr_mode`, `mstr_proc_val` and `mstr_data` are read combinationally from the array at `rd_ptr`.
  - They are forced to 0 while `mstr_valid`=0.

## Timing
- **Reset:** `rst`=1 at an edge clears `wr_ptr`, `rd_ptr`, `count` and `drop_cnt` to 0 at that edge. Array contents are not cleared.
- **Outputs after reset:**
  - `fifo_full`=0, `fifo_empty`=1, `mstr_valid`=0.
  - `mstr_*`=0, `fifo_count`=0, `drop_cnt`=0.
- **Reset mid-operation:** all pending entries are discarded. A push or pop in the reset cycle has no effect.
- **Write-to-read latency:** 1 cycle. A push at edge N into an empty FIFO gives `mstr_valid`=1 and the entry on the `mstr_*` outputs after edge N.
- **Pop timing:** a pop at edge N presents the next entry, or `mstr_valid`=0, after edge N.
- **Flag timing:** `fifo_full` and `fifo_empty` update in the cycle following the count change. They have no combinational path from `slvx_data_valid` or `mstr_rd_en`.
- **Headroom:** with the default FULL_MARGIN=2, `fifo_full` asserts at count 14. This leaves room for one in-flight arbiter push.

## Configuration
- **Macro:** `PIXEL_CMD_FIFO_DROP_CNT_EN`.
- **Defined:**
  - `drop_cnt` increments by 1 on every dropped push (overflow case above).
  - It saturates at 16'hFFFF and clears only on `rst`.
- **Not defined:**
  - The counter logic is absent and `drop_cnt` is tied to 16'h0000.
  - Overflow pushes are still dropped silently.

## Test plan
- **Reset and basic flow:** assert `rst` 2 cycles, then push `mode`=2'b01, `proc_val`=8'h3C, `data`=32'hDEADBEEF.
  - Required: `mstr_valid`=1 the next cycle with exactly those values.
  - Then pop: `mstr_valid`=0 and `mstr_*`=0.
- **Fill to full (DEPTH=16, FULL_MARGIN=2):** push 16 consecutive entries with `data`=0..15 and no pop.
  - Required: `fifo_full` rises after the 14th push and `fifo_count`=16 at the end.
  - Popping all 16 returns 0..15 in order, crossing the pointer wrap.
- **Overflow:** with the FIFO at count 16, push `data`=99 for 3 cycles.
  - Required: count stays 16 and the 16 popped entries are unchanged.
  - With the macro: `drop_cnt`=3. Without the macro: `drop_cnt`=0.
- **Simultaneous push and pop:**
  - At count 16: `fifo_count` remains 16, and the new entry appears after the 15 older entries.
  - At count 0: count becomes 1, and the pop has no effect.
- **Pop when empty:** hold `mstr_rd_en`=1 for 5 cycles on an empty FIFO.
  - Required: `fifo_count`=0 and `fifo_empty`=1 throughout.
  - A following push is read correctly, with no pointer skew.
- **Reset mid-operation:** push 7 entries, then assert `rst` for 1 cycle while pushing.
  - Required: count=0, `mstr_valid`=0 and `drop_cnt`=0 after the edge.
  - The next push is returned as the first entry.
